ram8: RTL
=========

# ram8

Eight-word register bank built around the 8-way load demultiplexer. It is the storage stage directly downstream of the demux. A single `load` strobe is steered by `address` to exactly one of eight WIDTH-bit registers, and the selected word is read back combinationally, following Hack RAM8 semantics. The block adds a per-word written mask and a sequenced 8-cycle clear, so higher RAM levels (RAM64 upward) and the test harness can scrub a bank without external address sweeping.

## Interface
- WIDTH, 16, bits per word
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in  input  WIDTH  write data
- load  input  1  write strobe for the word selected by `address`
- address  input  3  word select for both write and read
- clear  input  1  request to start the sequenced clear of all eight words
- out  output  WIDTH  contents of word[`address`], combinational read
- busy  output  1  high while the clear sequence runs
- written  output  8  bit k set when word k has been loaded since the last reset or clear

## Operation
- Load decode:
  - `load` is demuxed to a one-hot enable: `address`=000 selects word0, …, 111 selects word7.
  - When `address` = k, the enable for every word other than k is 0.
- Write:
  - Condition: rising edge with state IDLE, load=1 and clear=0.
  - Action: word[address] <= in; written[address] <= 1.
  - No other word changes.
- Read:
  - out = word[address] at all times, in every state.
  - A written value appears on `out` immediately after the write edge.
- States: IDLE, CLEAR. A 3-bit pointer `ptr` is used only in CLEAR.
- IDLE -> CLEAR:
  - Condition: clear=1 at a rising edge.
  - Action: ptr <= 0; busy goes to 1.
  - clear has priority over load: a load in the same cycle is dropped.
- CLEAR, each edge:
  - word[ptr] <= 0; written[ptr] <= 0; ptr <= ptr+1.
  - On the edge that clears word7, the state returns to IDLE and busy goes to 0.
- While in CLEAR, both `load` and `clear` are ignored. There is no queuing of either.
- Reset (rst_n=0):
  - Takes effect asynchronously at any time, including mid-clear.
  - All words = 0, written = 8'h00, busy = 0, state = IDLE, ptr = 0.
  - Therefore out = 0 while in reset.

## Timing
- Write latency:
  - Data sampled at edge N is visible on `out` after edge N, provided `address` is unchanged.
  - The read path is purely combinational from `address`.
- Clear:
  - clear is sampled at edge N, and busy=1 after edge N.
  - Words 0..7 are zeroed at edges N+1..N+8, respectively.
  - busy=0 after edge N+8.
  - A load presented in the cycle before edge N+8 is ignored; the first accepted load is at edge N+9.
- Holding clear=1 continuously:
  - The clear restarts once per 9 edges: one edge to enter CLEAR, then 8 clearing edges.
- written[k] changes only:
  - on a write edge to word k (set);
  - on the clear edge for word k (cleared);
  - on reset (cleared).
- Word width has no arithmetic. `in` is stored bit-exact; no truncation or extension occurs.
- Reset release:
  - Deassertion is synchronized by the clocking environment.
  - The first edge after release can accept a write.

## Test plan
- **Reset:** assert rst_n=0 mid-cycle -> out=0, busy=0, written=00, for every `address` 0..7.
- **One-hot write and read-back:**
  - Write 16'h1000+k to `address` k for k=0..7, one per edge.
  - Sweep `address` -> out=16'h1000+k; written=FF.
  - Each write changes only its own word.
- **Load low:** address=3, in=FFFF, load=0 for 4 edges -> word3 unchanged, written[3] unchanged.
- **Clear sequence:**
  - After a full bank, pulse clear at edge N -> busy=1 for edges N+1..N+8.
  - Hold address=5 -> out goes to 0 after edge N+6.
  - written bits drop in order 0..7; busy=0 and written=00 after N+8.
- **Collisions:**
  - clear=1 and load=1 at the same edge with address=2, in=ABCD -> word2 is not written and CLEAR is entered.
  - load during busy is ignored; load at edge N+9 succeeds.
- **Reset mid-clear:** assert rst_n=0 at cycle N+4 -> busy=0 and all words 0 immediately; the next write after release is accepted normally.

Source files
------------

// File: rtl/ram8_if.sv
// ram8_if: write/read/clear bus of the eight-word register bank
interface ram8_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] in;
    logic             load;
    logic [2:0]       address;
    logic             clear;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic [7:0]       written;
    modport master (output in, load, address, clear, input out, busy, written);
    modport slave (input in, load, address, clear, output out, busy, written);
endinterface

// File: rtl/ram8.sv
// ram8: eight-word register bank with demuxed load, written mask and sequenced clear
module ram8 #(parameter int WIDTH = 16) (
    input logic   clk,
    input logic   rst_n,
    ram8_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [8];
    logic [WIDTH-1:0] mem_d [8];
    logic [7:0]       written_q, written_d;
    logic [7:0]       en;
    // clear outranks load, and nothing is accepted while clearing
    assign en = (state_q == IDLE && bus.load && !bus.clear) ? 8'(8'd1 << bus.address) : 8'd0;
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_d     = mem_q;
        written_d = written_q;
        if (state_q == IDLE) begin
            if (bus.clear) begin
                state_d = CLEAR;
                ptr_d   = 3'd0;
            end
            for (int k = 0; k < 8; k++) begin
                if (en[k]) begin
                    mem_d[k]     = bus.in;
                    written_d[k] = 1'b1;
                end
            end
        end else begin
            mem_d[ptr_q]     = '0;
            written_d[ptr_q] = 1'b0;
            ptr_d            = ptr_q + 3'd1;
            state_d          = (ptr_q == 3'd7) ? IDLE : CLEAR;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            mem_q     <= '{default: '0};
            written_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            mem_q     <= mem_d;
            written_q <= written_d;
        end
    end
    assign bus.out     = mem_q[bus.address];
    assign bus.busy    = (state_q == CLEAR);
    assign bus.written = written_q;
endmodule
